shift_unit_seq: RTL

//   Iterative shift unit: shifts a 32-bit operand one bit position per clock.

---
 rtl/shift_unit_seq.sv | 63 ++++++
 1 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative one-bit-per-clock shifter/rotator feeding the ALUOut mux SHIFTER input.
// A start in IDLE latches the operand and amount; DONE pulses once the requested number of single-bit steps has run.
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         shift_op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d, step;
    logic [2:0]         op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               accept, fill;
    assign accept   = (state_q == IDLE) && start;
    assign data_out = data_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // Zero amount and reserved ops skip SHIFT so the operand passes through untouched.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = !start ? IDLE : (shamt == '0 || shift_op > 3'd4) ? DONE : SHIFT;
        else if (state_q == SHIFT)
            state_d = (cnt_q == SHAMT_W'(1)) ? DONE : SHIFT;
        else
            state_d = IDLE;
    end
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end
    always_comb begin
        fill = (op_q == 3'd2) ? data_q[WIDTH-1] : (op_q == 3'd3) ? data_q[0] : 1'b0;
        step = (op_q == 3'd0) ? {data_q[WIDTH-2:0], 1'b0} :
               (op_q == 3'd4) ? {data_q[WIDTH-2:0], data_q[WIDTH-1]} :
                                {fill, data_q[WIDTH-1:1]};
        data_d = accept ? data_in : busy ? step : data_q;
        op_d   = accept ? shift_op : op_q;
        cnt_d  = accept ? shamt : busy ? cnt_q - SHAMT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
